// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory access arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REG, S_RAM, S_RESP} arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int N_REGS_DEF      = 10;
  localparam int RAM_TIMEOUT_DEF = 15;
  localparam int DATA_W          = 16;
endpackage

// File: rtl/mem_access_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port not served last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);
  always_comb begin
    grant = PORT_FETCH;
    if (req == 2'b11) grant = ~last;
    else if (req[1])  grant = PORT_DATA;
  end
endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates fetch and data ports onto a register file (one cycle) or a
// handshaked RAM with a bounded wait; one completion pulse per transaction.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REGS      = N_REGS_DEF,
  parameter int RAM_TIMEOUT = RAM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [N_REGS-1:0] reg_sel,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              ram_s,
  output logic [DATA_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);
  localparam int CNT_W = $clog2(RAM_TIMEOUT + 1);

  arb_state_e        state, state_nxt;
  logic              grant;
  logic              last_q;
  logic              lat_port, lat_we;
  logic [DATA_W-1:0] lat_addr, lat_wdata;
  logic [DATA_W-1:0] sel_addr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ram_expired;

  rr_arb2 u_rr (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  assign sel_addr    = grant ? addr1 : addr0;
  assign ram_expired = (wait_cnt == CNT_W'(RAM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (|req) state_nxt = (sel_addr < DATA_W'(N_REGS)) ? S_REG : S_RAM;
      S_REG:  state_nxt = S_RESP;
      S_RAM:  if (ram_ready || ram_expired) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture: only meaningful once a grant moves the FSM out of IDLE.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && |req) begin
      lat_port  <= grant;
      lat_we    <= we[grant];
      lat_addr  <= sel_addr;
      lat_wdata <= grant ? wdata1 : wdata0;
    end
  end

  // Completion bookkeeping; READY beats the timeout when both land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
      last_q   <= PORT_DATA;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          err_q    <= 1'b0;
        end
        S_REG: rdata_q <= lat_we ? '0 : reg_rdata;
        S_RAM: begin
          if (ram_ready) begin
            rdata_q <= lat_we ? '0 : ram_rdata;
            err_q   <= 1'b0;
          end else if (ram_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: last_q <= lat_port;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack       = '0;
    err       = 1'b0;
    reg_sel   = '0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    ram_s     = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    rdata     = rdata_q;
    case (state)
      S_REG: begin
        for (int i = 0; i < N_REGS; i++) reg_sel[i] = (lat_addr == DATA_W'(i));
        reg_we    = lat_we;
        reg_wdata = lat_wdata;
      end
      S_RAM: begin
        ram_s     = 1'b1;
        ram_addr  = lat_addr;
        ram_we    = lat_we;
        ram_wdata = lat_wdata;
      end
      S_RESP: begin
        ack[lat_port] = 1'b1;
        err           = err_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: register vectors from a table plus
// hand sequences for RAM wait, timeout, round-robin and reset corners.
module tb_mem_access_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  ack;
  logic        err;
  logic [15:0] rdata;
  logic [9:0]  reg_sel;
  logic        reg_we;
  logic [15:0] reg_wdata, reg_rdata;
  logic        ram_s;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata, ram_rdata;
  logic        ram_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(.N_REGS(10), .RAM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata),
    .reg_sel(reg_sel), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .ram_s(ram_s), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  typedef struct {
    logic [1:0]  req, we;
    logic [15:0] a0, a1, wd0, wd1, rrd;
    logic [9:0]  e_sel;
    logic        e_we;
    logic [15:0] e_wd;
    logic [1:0]  e_ack;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 2'b00;
    ram_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; reg_rdata = '0; ram_rdata = '0; ram_ready = 1'b0;

    //            req    we     a0       a1       wd0      wd1      rrd      sel     we    wd       ack    rdata
    vecs[0] = '{2'b01, 2'b00, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 10'h008, 1'b0, 16'h0000, 2'b01, 16'h1234};
    vecs[1] = '{2'b10, 2'b10, 16'h0000, 16'h0009, 16'h0000, 16'hBEEF, 16'h4321, 10'h200, 1'b1, 16'hBEEF, 2'b10, 16'h0000};
    vecs[2] = '{2'b11, 2'b00, 16'h0000, 16'h0005, 16'h1111, 16'h2222, 16'h5555, 10'h001, 1'b0, 16'h1111, 2'b01, 16'h5555};
    vecs[3] = '{2'b11, 2'b00, 16'h0000, 16'h0005, 16'h1111, 16'h2222, 16'hAAAA, 10'h020, 1'b0, 16'h2222, 2'b10, 16'hAAAA};
    vecs[4] = '{2'b01, 2'b01, 16'h0000, 16'h0000, 16'h0F0F, 16'h0000, 16'h6666, 10'h001, 1'b1, 16'h0F0F, 2'b01, 16'h0000};
    vecs[5] = '{2'b10, 2'b00, 16'h0000, 16'h0007, 16'h0000, 16'h0000, 16'h7777, 10'h080, 1'b0, 16'h0000, 2'b10, 16'h7777};

    step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_reg_sel", 32'(reg_sel), 0);
    chk("rst_ram_s", 32'(ram_s), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      req = vecs[i].req; we = vecs[i].we; addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      wdata0 = vecs[i].wd0; wdata1 = vecs[i].wd1; reg_rdata = vecs[i].rrd;
      chk($sformatf("v%0d_c0_ack", i), 32'(ack), 0);
      step();
      req = 2'b00;
      chk($sformatf("v%0d_sel", i), 32'(reg_sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_reg_we", i), 32'(reg_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_reg_wdata", i), 32'(reg_wdata), 32'(vecs[i].e_wd));
      chk($sformatf("v%0d_c1_ack", i), 32'(ack), 0);
      chk($sformatf("v%0d_c1_ram_s", i), 32'(ram_s), 0);
      step();
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_err", i), 32'(err), 0);
      chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
      chk($sformatf("v%0d_c2_sel", i), 32'(reg_sel), 0);
      step();
      chk($sformatf("v%0d_c3_ack", i), 32'(ack), 0);
    end

    // Tie from reset with requests held through completion.
    do_reset();
    req = 2'b11; we = 2'b00; addr0 = 16'h0020; addr1 = 16'h0005; ram_ready = 1'b1;
    step();
    chk("tie_ram_s", 32'(ram_s), 1);
    chk("tie_ram_addr", 32'(ram_addr), 32'h0020);
    step();
    chk("tie_ack_fetch", 32'(ack), 32'b01);
    step();
    chk("held_no_regrant_sel", 32'(reg_sel), 0);
    chk("held_no_regrant_ack", 32'(ack), 0);
    step();
    chk("tie_data_sel", 32'(reg_sel), 32'h020);
    step();
    chk("tie_ack_data", 32'(ack), 32'b10);
    req = 2'b00; ram_ready = 1'b0;
    step();

    // Data write to RAM, READY in the fourth RAM cycle.
    req = 2'b10; we = 2'b10; addr1 = 16'h0040; wdata1 = 16'hCAFE;
    step();
    req = 2'b00;
    cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) ram_ready = 1'b1;
      if (ram_s && ram_we && ram_addr == 16'h0040 && ram_wdata == 16'hCAFE) cnt++;
      step();
    end
    ram_ready = 1'b0;
    chk("wr_ram_cycles", 32'(cnt), 4);
    chk("wr_ack", 32'(ack), 32'b10);
    chk("wr_err", 32'(err), 0);
    chk("wr_rdata", 32'(rdata), 0);
    chk("wr_ram_s_off", 32'(ram_s), 0);
    step();

    // RAM read with immediate READY so RDATA becomes nonzero.
    req = 2'b10; we = 2'b00; addr1 = 16'h8000; ram_rdata = 16'h3C3C; ram_ready = 1'b1;
    step();
    req = 2'b00;
    chk("rd_ram_we", 32'(ram_we), 0);
    step();
    ram_ready = 1'b0;
    chk("rd_ack", 32'(ack), 32'b10);
    chk("rd_rdata", 32'(rdata), 32'h3C3C);
    step();
    chk("rd_rdata_hold", 32'(rdata), 32'h3C3C);

    // Timeout: READY never comes.
    req = 2'b01; we = 2'b00; addr0 = 16'h1000;
    step();
    req = 2'b00;
    cnt = 0;
    while (ram_s && cnt < 20) begin
      cnt++;
      step();
    end
    chk("to_ram_cycles", 32'(cnt), 15);
    chk("to_ack", 32'(ack), 32'b01);
    chk("to_err", 32'(err), 1);
    chk("to_rdata", 32'(rdata), 0);
    step();
    chk("to_err_clear", 32'(err), 0);

    // READY on the final allowed RAM cycle wins over the timeout.
    req = 2'b01; addr0 = 16'hFFFF; ram_rdata = 16'h9999;
    step();
    req = 2'b00;
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) begin
        ram_ready = 1'b1;
        chk("last_ram_s", 32'(ram_s), 1);
      end
      step();
    end
    ram_ready = 1'b0;
    chk("last_ack", 32'(ack), 32'b01);
    chk("last_err", 32'(err), 0);
    chk("last_rdata", 32'(rdata), 32'h9999);
    step();

    // Reset in the middle of a RAM wait.
    req = 2'b01; addr0 = 16'h2000;
    step();
    req = 2'b00;
    step();
    chk("mid_ram_s", 32'(ram_s), 1);
    #2 rst = 1'b1;
    #1 chk("async_ram_s", 32'(ram_s), 0);
    chk("async_rdata", 32'(rdata), 0);
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (ack != 2'b00 || ram_s) cnt++;
      step();
    end
    chk("post_rst_quiet", 32'(cnt), 0);

    // Address boundary: 9 is a register, 10 is RAM.
    req = 2'b01; addr0 = 16'd9; reg_rdata = 16'h0909;
    step();
    req = 2'b00;
    chk("bound9_sel", 32'(reg_sel), 32'h200);
    chk("bound9_ram_s", 32'(ram_s), 0);
    step();
    chk("bound9_ack", 32'(ack), 32'b01);
    step();
    req = 2'b01; addr0 = 16'd10; ram_ready = 1'b1;
    step();
    req = 2'b00;
    chk("bound10_ram_s", 32'(ram_s), 1);
    chk("bound10_sel", 32'(reg_sel), 0);
    step();
    ram_ready = 1'b0;
    chk("bound10_ack", 32'(ack), 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 N_REGS, default 10, meaning: number of one-hot register selects; addresses 0..N_REGS-1 map to registers, all others to RAM.
REQ-002 RAM_TIMEOUT, default 15, meaning: maximum cycles spent waiting for RAM_READY before an error completion.
REQ-003 CLK  input  1  rising-edge clock; the block has one clock.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 REQ  input  2  access request; bit0 = fetch port, bit1 = data port.
REQ-006 WE  input  2  per-port write enable, sampled with REQ.
REQ-007 ADDR0, ADDR1  input  16 each  per-port address.
REQ-008 WDATA0, WDATA1  input  16 each  per-port write data.
REQ-009 ACK  output  2  one-cycle completion pulse, bit per port.
REQ-010 ERR  output  1  timeout flag, valid only with ACK.
REQ-011 RDATA  output  16  read data, valid with ACK.
REQ-012 REG_SEL  output  N_REGS  one-hot register select; REG_WE output 1; REG_WDATA output 16; REG_RDATA input 16.
REQ-013 RAM_S  output  1  RAM transaction active; RAM_ADDR output 16; RAM_WE output 1; RAM_WDATA output 16; RAM_RDATA input 16; RAM_READY input 1.

Function
REQ-014 The FSM SHALL have states IDLE, REG, RAM, RESP; all outputs SHALL be decoded from registered state only (no REQ-to-output combinational path).
REQ-015 In IDLE with any REQ bit high, the block SHALL grant one port, latching its ADDR, WE, WDATA and port index.
REQ-016 Both requesting: grant SHALL go to the port not served last (round-robin); a single requester SHALL be granted regardless of history.
REQ-017 Latched address < N_REGS SHALL go to REG; otherwise to RAM (0xFFFF and N_REGS itself go to RAM).
REQ-018 REG SHALL last exactly one cycle: REG_SEL = one-hot of latched address, REG_WE = latched WE, REG_WDATA = latched data; REG_RDATA captured at end of cycle; next state RESP.
REQ-019 RAM SHALL drive RAM_S=1, RAM_ADDR = full latched address (no offset), RAM_WE, RAM_WDATA, all stable until exit.
REQ-020 RAM SHALL exit to RESP on the first edge RAM_READY is sampled high, capturing RAM_RDATA.
REQ-021 A wait counter SHALL count cycles in RAM; on reaching RAM_TIMEOUT without READY, exit to RESP with ERR set; READY in that same cycle SHALL win (no ERR).
REQ-022 RESP SHALL last one cycle: ACK[port]=1, ERR as determined, RDATA = captured data (0 on write or error); the last-served pointer updates; next state IDLE.
REQ-023 Register latency: REQ seen cycle 0 -> REG cycle 1 -> ACK cycle 2; RAM: ACK the cycle after READY sampled.
REQ-024 REQ deassertion after grant SHALL be ignored; the transaction completes and ACKs.
REQ-025 REQ still high during ACK SHALL NOT be re-granted until the following IDLE cycle (minimum 3 cycles between grants).
REQ-026 Outside their states: REG_SEL=0, REG_WE=0, RAM_S=0, RAM_WE=0, ACK=0, ERR=0; RDATA holds its last value.

Reset
REQ-027 RST SHALL asynchronously force IDLE, all outputs 0, RDATA 0, counter 0, last-served = data port (fetch wins the first tie).
REQ-028 RST mid-transaction SHALL drop RAM_S/REG_SEL immediately and issue no ACK; requesters re-request.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum, port index constants and N_REGS/RAM_TIMEOUT defaults.
REQ-030 Two-way round-robin selection SHALL be a sub-module rr_arb2 (inputs: req[1:0], last; output: grant index).

Verification
REQ-031 Fetch reads ADDR0=3, REG_RDATA=0x1234 -> REG_SEL=0b0000001000 cycle 1, ACK=01 cycle 2, RDATA=0x1234.
REQ-032 Both request from reset (ADDR0=0x0020, ADDR1=5) -> fetch served first, data port next; a second simultaneous pair -> data port first.
REQ-033 Data write ADDR1=0x0040, RAM_READY high after 4 cycles -> RAM_S high 4 cycles, RAM_WE=1, ACK=10, ERR=0, RDATA=0.
REQ-034 RAM read with RAM_READY never asserted -> ACK after 15 RAM cycles with ERR=1, RDATA=0; READY on cycle 15 -> ERR=0.
REQ-035 RST pulsed during RAM wait -> RAM_S=0 asynchronously, no ACK, idle after release; ADDR=9 -> REG, ADDR=10 -> RAM.
